// File: rtl/sync_fifo_flags.sv
// -----------------------------------------------------------------------------
// sync_fifo_flags
//
// Single-clock FIFO with arbitrary depth, an occupancy count, runtime
// almost-full / almost-empty thresholds, a synchronous flush, and sticky
// overflow / underflow error flags. Two read modes can be selected at
// elaboration: first-word-fall-through (FWFT=1) or registered output (FWFT=0).
//
// Parameters
//   DATA_WIDTH  word width in bits
//   FIFO_DEPTH  number of entries (>= 2, any integer)
//   FWFT        1 = head word presented combinationally, 0 = one-cycle read
//   CNT_WIDTH   width of count and threshold ports (derived)
//
// Ports
//   clk_i                  clock, rising edge
//   reset_n_i              synchronous active-low reset
//   flush_i                synchronous clear of contents and error flags
//   clr_err_i              clears overflow_o / underflow_o
//   wr_en_i, data_in_i     write request and data
//   rd_en_i                read request (pop / acknowledge in FWFT mode)
//   data_out_o, rd_valid_o read data and its qualifier
//   full_o, empty_o        occupancy extremes
//   almost_full_thresh_i   almost_full_o  = count_o >= threshold
//   almost_empty_thresh_i  almost_empty_o = count_o <= threshold
//   count_o                current occupancy, 0..FIFO_DEPTH
//   overflow_o             sticky: write attempted while full
//   underflow_o            sticky: read attempted while empty
// -----------------------------------------------------------------------------
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter bit FWFT       = 1'b1,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] data_in_i,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [CNT_WIDTH-1:0]  almost_full_thresh_i,
    input  logic [CNT_WIDTH-1:0]  almost_empty_thresh_i,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int                 PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]   LAST    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);

    // Storage is never reset; only the pointers and count define validity.
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 overflow_q;
    logic                 underflow_q;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic ovf_set;
    logic udf_set;

    // Explicit wrap so non-power-of-two depths cycle through 0..FIFO_DEPTH-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Flags derive only from the count register.
    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);

    // Accepts are decided on pre-edge state: a write into an empty FIFO is
    // not readable this cycle, and a read from a full FIFO does not make room
    // for a same-cycle write. Flush suppresses both.
    assign wr_acc  = wr_en_i & ~full  & ~flush_i;
    assign rd_acc  = rd_en_i & ~empty & ~flush_i;
    assign ovf_set = wr_en_i & full  & ~flush_i;
    assign udf_set = rd_en_i & empty & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (reset_n_i && wr_acc) begin
            mem[wr_ptr_q] <= data_in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky error flags: a new error event wins over clr_err_i.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || flush_i) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end else if (clr_err_i) begin
                overflow_q <= 1'b0;
            end
            if (udf_set) begin
                underflow_q <= 1'b1;
            end else if (clr_err_i) begin
                underflow_q <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word shown with zero latency; forced to 0 when empty so
            // downstream never sees stale memory.
            assign data_out_o = empty ? '0 : mem[rd_ptr_q];
            assign rd_valid_o = ~empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] data_q;
            logic                  valid_q;

            // Data holds its last value between reads; valid pulses for the
            // single cycle after an accepted read.
            always_ff @(posedge clk_i) begin
                if (!reset_n_i || flush_i) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_acc;
                    if (rd_acc) begin
                        data_q <= mem[rd_ptr_q];
                    end
                end
            end

            assign data_out_o = data_q;
            assign rd_valid_o = valid_q;
        end
    endgenerate

    assign full_o         = full;
    assign empty_o        = empty;
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // Live thresholds: a threshold change is reflected in the same cycle.
    assign almost_full_o  = (count_q >= almost_full_thresh_i);
    assign almost_empty_o = (count_q <= almost_empty_thresh_i);

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: depth 16, first-word-fall-through
    logic       a_flush, a_clr, a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_valid, a_full, a_empty, a_afo, a_aeo, a_ovf, a_udf;
    logic [4:0] a_af, a_ae, a_count;

    // Instance B: depth 5, registered read
    logic       b_flush, b_clr, b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_valid, b_full, b_empty, b_afo, b_aeo, b_ovf, b_udf;
    logic [2:0] b_af, b_ae, b_count;

    sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b1)) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(a_flush), .clr_err_i(a_clr),
        .wr_en_i(a_wr), .data_in_i(a_din), .rd_en_i(a_rd),
        .data_out_o(a_dout), .rd_valid_o(a_valid), .full_o(a_full), .empty_o(a_empty),
        .almost_full_thresh_i(a_af), .almost_empty_thresh_i(a_ae),
        .almost_full_o(a_afo), .almost_empty_o(a_aeo), .count_o(a_count),
        .overflow_o(a_ovf), .underflow_o(a_udf)
    );

    sync_fifo_flags #(.DATA_WIDTH(8), .FIFO_DEPTH(5), .FWFT(1'b0)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .flush_i(b_flush), .clr_err_i(b_clr),
        .wr_en_i(b_wr), .data_in_i(b_din), .rd_en_i(b_rd),
        .data_out_o(b_dout), .rd_valid_o(b_valid), .full_o(b_full), .empty_o(b_empty),
        .almost_full_thresh_i(b_af), .almost_empty_thresh_i(b_ae),
        .almost_full_o(b_afo), .almost_empty_o(b_aeo), .count_o(b_count),
        .overflow_o(b_ovf), .underflow_o(b_udf)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] sb [$];
    logic [7:0] bq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int         mcount;
    int         wrs;
    int         rds;
    int         cyc;
    logic       wacc;
    logic       racc;
    logic [7:0] exp_d;

    initial begin
        rst_n = 1'b0;
        a_flush = 0; a_clr = 0; a_wr = 0; a_rd = 0; a_din = 0;
        b_flush = 0; b_clr = 0; b_wr = 0; b_rd = 0; b_din = 0;
        a_af = 5'd12; a_ae = 5'd2;
        b_af = 3'd4;  b_ae = 3'd1;
        tick();
        tick();

        // Reset state
        chk("a_rst_count", 32'(a_count), 32'd0);
        chk("a_rst_empty", 32'(a_empty), 32'd1);
        chk("a_rst_full",  32'(a_full),  32'd0);
        chk("a_rst_ae",    32'(a_aeo),   32'd1);
        chk("a_rst_af",    32'(a_afo),   32'd0);
        chk("a_rst_ovf",   32'(a_ovf),   32'd0);
        chk("a_rst_udf",   32'(a_udf),   32'd0);
        chk("a_rst_dout",  32'(a_dout),  32'd0);
        chk("a_rst_valid", 32'(a_valid), 32'd0);
        chk("b_rst_dout",  32'(b_dout),  32'd0);
        chk("b_rst_valid", 32'(b_valid), 32'd0);
        chk("b_rst_empty", 32'(b_empty), 32'd1);
        a_af = 5'd0;
        #1;
        chk("a_af_thresh0", 32'(a_afo), 32'd1);
        a_af = 5'd12;
        rst_n = 1'b1;
        tick();

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            a_wr = 1; a_din = 8'(i);
            tick();
            sb.push_back(8'(i));
            chk("a_fill_count", 32'(a_count), 32'(i + 1));
            chk("a_fill_full",  32'(a_full),  32'(i == 15));
            chk("a_fill_empty", 32'(a_empty), 32'd0);
            chk("a_fill_af",    32'(a_afo),   32'(i + 1 >= 12));
            chk("a_fill_ae",    32'(a_aeo),   32'(i + 1 <= 2));
            chk("a_fill_head",  32'(a_dout),  32'(sb[0]));
        end
        a_din = 8'hAA;
        tick();
        a_wr = 0;
        chk("a_ovf_count", 32'(a_count), 32'd16);
        chk("a_ovf_flag",  32'(a_ovf),   32'd1);
        chk("a_ovf_head",  32'(a_dout),  32'(sb[0]));

        // Drain
        for (int k = 0; k < 16; k++) begin
            a_rd = 1;
            chk("a_drain_data",  32'(a_dout),  32'(sb[0]));
            chk("a_drain_valid", 32'(a_valid), 32'd1);
            tick();
            void'(sb.pop_front());
            chk("a_drain_count", 32'(a_count), 32'(15 - k));
        end
        chk("a_drained_empty", 32'(a_empty), 32'd1);
        chk("a_drained_dout",  32'(a_dout),  32'd0);
        chk("a_drained_valid", 32'(a_valid), 32'd0);
        tick();
        chk("a_udf_flag",  32'(a_udf), 32'd1);
        a_clr = 1;
        tick();
        chk("a_udf_setwins", 32'(a_udf), 32'd1);
        chk("a_ovf_cleared", 32'(a_ovf), 32'd0);
        a_rd = 0;
        tick();
        a_clr = 0;
        chk("a_clr_udf", 32'(a_udf), 32'd0);
        chk("a_clr_ovf", 32'(a_ovf), 32'd0);

        // rd+wr at empty
        a_rd = 1; a_wr = 1; a_din = 8'h50;
        tick();
        sb.push_back(8'h50);
        a_rd = 0; a_wr = 0;
        chk("a_rdwr_empty_count", 32'(a_count), 32'd1);
        chk("a_rdwr_empty_udf",   32'(a_udf),   32'd1);
        chk("a_rdwr_empty_head",  32'(a_dout),  32'h50);
        a_clr = 1;
        tick();
        a_clr = 0;
        for (int i = 1; i < 3; i++) begin
            a_wr = 1; a_din = 8'(8'h50 + i);
            tick();
            sb.push_back(8'(8'h50 + i));
        end
        // rd+wr at count 3
        a_rd = 1; a_din = 8'h53;
        chk("a_rdwr3_head", 32'(a_dout), 32'(sb[0]));
        tick();
        void'(sb.pop_front());
        sb.push_back(8'h53);
        a_rd = 0;
        chk("a_rdwr3_count", 32'(a_count), 32'd3);
        chk("a_rdwr3_udf",   32'(a_udf),   32'd0);
        for (int i = 0; i < 13; i++) begin
            a_din = 8'(8'h60 + i);
            tick();
            sb.push_back(8'(8'h60 + i));
        end
        chk("a_refill_full", 32'(a_full), 32'd1);
        // rd+wr at full: read accepted, write rejected
        a_rd = 1; a_din = 8'h77;
        chk("a_rdwr_full_head", 32'(a_dout), 32'(sb[0]));
        tick();
        void'(sb.pop_front());
        a_rd = 0; a_wr = 0;
        chk("a_rdwr_full_count", 32'(a_count), 32'd15);
        chk("a_rdwr_full_ovf",   32'(a_ovf),   32'd1);

        // Drain to 8 and exercise live threshold
        for (int k = 0; k < 7; k++) begin
            a_rd = 1;
            chk("a_order_data", 32'(a_dout), 32'(sb[0]));
            tick();
            void'(sb.pop_front());
        end
        a_rd = 0;
        chk("a_cnt8",    32'(a_count), 32'd8);
        chk("a_af_at8",  32'(a_afo),   32'd0);
        chk("a_ae_at8",  32'(a_aeo),   32'd0);
        a_af = 5'd4;
        #1;
        chk("a_af_live", 32'(a_afo), 32'd1);
        a_af = 5'd12;

        // Flush at count 9 with overflow set
        a_wr = 1; a_din = 8'h99;
        tick();
        sb.push_back(8'h99);
        chk("a_pre_flush_count", 32'(a_count), 32'd9);
        chk("a_pre_flush_ovf",   32'(a_ovf),   32'd1);
        a_flush = 1; a_rd = 1; a_din = 8'hEE;
        tick();
        a_flush = 0; a_wr = 0; a_rd = 0;
        sb.delete();
        chk("a_flush_count", 32'(a_count), 32'd0);
        chk("a_flush_empty", 32'(a_empty), 32'd1);
        chk("a_flush_ovf",   32'(a_ovf),   32'd0);
        chk("a_flush_udf",   32'(a_udf),   32'd0);
        chk("a_flush_dout",  32'(a_dout),  32'd0);
        a_wr = 1; a_din = 8'hC3;
        tick();
        a_wr = 0;
        chk("a_post_flush_data",  32'(a_dout),  32'hC3);
        chk("a_post_flush_count", 32'(a_count), 32'd1);
        a_rd = 1;
        tick();
        a_rd = 0;
        chk("a_post_flush_empty", 32'(a_empty), 32'd1);

        // Instance B: 40 interleaved words through depth 5, registered read
        mcount = 0; wrs = 0; rds = 0; cyc = 0; exp_d = 8'h00;
        while (rds < 40 && cyc < 400) begin
            wacc = ((cyc % 7) < 4) && (wrs < 40) && (mcount < 5);
            racc = ((cyc % 5) < 3) && (mcount > 0);
            b_wr  = wacc;
            b_rd  = racc;
            b_din = 8'(16 + wrs * 3);
            if (racc) exp_d = bq.pop_front();
            if (wacc) begin
                bq.push_back(b_din);
                wrs++;
            end
            tick();
            mcount = mcount + int'(wacc) - int'(racc);
            if (racc) rds++;
            chk("b_valid", 32'(b_valid), 32'(racc));
            chk("b_data",  32'(b_dout),  32'(exp_d));
            chk("b_count", 32'(b_count), 32'(mcount));
            chk("b_af",    32'(b_afo),   32'(mcount >= 4));
            chk("b_ae",    32'(b_aeo),   32'(mcount <= 1));
            cyc++;
        end
        b_wr = 0; b_rd = 0;
        chk("b_all_read",    32'(rds), 32'd40);
        chk("b_all_written", 32'(wrs), 32'd40);
        chk("b_no_ovf",      32'(b_ovf), 32'd0);
        chk("b_no_udf",      32'(b_udf), 32'd0);
        tick();
        chk("b_hold_data",  32'(b_dout),  32'(exp_d));
        chk("b_hold_valid", 32'(b_valid), 32'd0);
        b_flush = 1;
        tick();
        b_flush = 0;
        chk("b_flush_dout",  32'(b_dout),  32'd0);
        chk("b_flush_valid", 32'(b_valid), 32'd0);
        chk("b_flush_count", 32'(b_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Parametrised single-clock FIFO that supersedes the basic synchronous FIFO for UART TX/RX buffering and other same-clock queues. It adds arbitrary (non-power-of-two) depth, an occupancy count, runtime almost-full and almost-empty thresholds, and a synchronous flush. It also provides sticky overflow/underflow error flags and a selectable read mode: first-word-fall-through or registered output. It sits between the register interface and the UART TX/RX engines and feeds interrupt and status logic directly.

## Interface
- DATA_WIDTH, 8, word width in bits (≥1)
- FIFO_DEPTH, 16, number of entries; any integer ≥2, power of two not required
- FWFT, 1, 1 = first-word-fall-through read; 0 = registered read (one-cycle latency)
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), derived; width of count and threshold ports

Ports:
- clk_i  input  1  clock; all logic on rising edge
- reset_n_i  input  1  reset, synchronous, active-low
- flush_i  input  1  synchronous clear of FIFO contents and error flags
- clr_err_i  input  1  clears overflow_o/underflow_o
- wr_en_i  input  1  write request
- data_in_i  input  DATA_WIDTH  write data
- rd_en_i  input  1  read request
- data_out_o  output  DATA_WIDTH  read data
- rd_valid_o  output  1  data_out_o holds a valid word
- full_o  output  1  count == FIFO_DEPTH
- empty_o  output  1  count == 0
- almost_full_thresh_i  input  CNT_WIDTH  almost-full level
- almost_empty_thresh_i  input  CNT_WIDTH  almost-empty level
- almost_full_o  output  1  count ≥ almost_full_thresh_i
- almost_empty_o  output  1  count ≤ almost_empty_thresh_i
- count_o  output  CNT_WIDTH  current occupancy, 0..FIFO_DEPTH
- overflow_o  output  1  sticky: write attempted while full
- underflow_o  output  1  sticky: read attempted while empty

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array, write-only on accepted writes; never reset.
- Pointers and count:
  - Binary wr/rd pointers of $clog2(FIFO_DEPTH) bits; each wraps from FIFO_DEPTH-1 to 0 (explicit compare, not natural overflow).
  - count register is the single source for full/empty/almost flags.
- Accept rules:
  - wr_acc = wr_en_i & !full_o.
  - rd_acc = rd_en_i & !empty_o.
  - Both are evaluated on the pre-edge state, so a write to an empty FIFO is not readable in the same cycle.
  - A read from a full FIFO does not free space for a same-cycle write.
- Count update: +1 on wr_acc only; −1 on rd_acc only; unchanged when both or neither.
- Errors:
  - overflow_o sets on wr_en_i & full_o; underflow_o sets on rd_en_i & empty_o.
  - Both are cleared by clr_err_i or flush_i; set wins over clr_err_i in the same cycle.
- Flush:
  - flush_i clears pointers, count and error flags, and in FWFT=0 also rd_valid_o and data_out_o.
  - It has priority over wr_en_i/rd_en_i; those requests are ignored and raise no error flags.
  - Memory contents are untouched.
- Read modes:
  - FWFT=1: data_out_o = mem[rd_ptr] when !empty_o, else 0; rd_valid_o = !empty_o (combinational from registered state). rd_en_i acts as acknowledge/pop.
  - FWFT=0: on rd_acc, data_out_o registers mem[rd_ptr] and rd_valid_o is 1 for the following cycle. Otherwise rd_valid_o is 0 and data_out_o holds its last value.
- Almost flags: combinational compares of count against the live threshold inputs. Threshold 0 for almost-full gives a constant 1; threshold FIFO_DEPTH for almost-empty gives a constant 1.

## Timing
- Reset (reset_n_i low at an edge):
  - pointers, count, overflow_o, underflow_o, rd_valid_o and data_out_o go to 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = (almost_full_thresh_i == 0).
  - Reset has priority over flush_i.
- Write accepted at edge N: count_o, full_o, empty_o and almost flags reflect it from N+. In FWFT=1 the word is visible on data_out_o from N+ if it became head.
- FWFT=1 read: head is presented with zero latency; rd_en_i at edge N advances to the next word, visible at N+.
- FWFT=0 read: rd_en_i accepted at edge N; data_out_o/rd_valid_o valid during cycle N+1 only. Back-to-back reads give one word per cycle.
- Simultaneous write and read, 0 < count < FIFO_DEPTH: both accepted; count unchanged.
- Wrap-around: pointers continue correctly across index FIFO_DEPTH-1 → 0 for non-power-of-two depths; data order is preserved.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset, then fill, FIFO_DEPTH=16, FWFT=1: write 0x00..0x0F.
  - Expect count_o 1..16, full_o at 16, empty_o 0 after the first write.
  - A 17th write leaves data unchanged, count_o=16, overflow_o=1.
- Drain: read 16 words, expect 0x00..0x0F in order, then empty_o=1 and data_out_o=0. A 17th read sets underflow_o=1; clr_err_i clears both error flags next cycle.
- FIFO_DEPTH=5, FWFT=0: run 40 interleaved writes/reads of an incrementing pattern.
  - Pointers wrap repeatedly; every word returns exactly once, one cycle after its rd_en_i, with rd_valid_o set.
- Simultaneous rd+wr: at count=3 count stays 3. At empty, rd+wr gives count=1 and underflow_o=1. At full, rd+wr gives count=15 and overflow_o=1.
- Thresholds AF=12, AE=2: almost_empty_o is 1 for count ≤2; almost_full_o is 1 for count ≥12. Changing AF to 4 at count=8 asserts almost_full_o in the same cycle.
- Flush at count=9 with wr_en_i=rd_en_i=1 and overflow_o set: next cycle count_o=0, empty_o=1, error flags 0. A following write/read returns the new data, not stale data.
